vram_arbiter: RTL
=================

# vram_arbiter

Single-port video RAM arbiter that shares one synchronous VRAM between the `video` scan-out fetch path and the CPU bus. Video fetches have absolute priority and fixed latency, so pixel timing is never disturbed. CPU accesses fill the slots where no fetch is requested, using a level request / pulse acknowledge handshake. The block sits between `video`, the CPU bus decoder and the VRAM macro, and runs on the 100 MHz system clock.

## Interface
- `AW`, 15: VRAM address width (words).
- `DW`, 8: VRAM data width.
- `STARVE_LIMIT`, 64: CPU wait cycles that set the `starve` flag; range 1..255.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `vid_req`  in  1  single-cycle fetch strobe from `video`.
- `vid_addr`  in  AW  fetch address, valid with `vid_req`.
- `vid_valid`  out  1  one-cycle pulse, `vid_data` valid.
- `vid_data`  out  DW  fetched word, held until next `vid_valid`.
- `cpu_req`  in  1  CPU request level, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr`  in  AW  CPU address; stable while `cpu_req`.
- `cpu_wdata`  in  DW  CPU write data; stable while `cpu_req`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  read data, valid with `cpu_ack` on reads, held otherwise.
- `ram_en`  out  1  VRAM enable (registered).
- `ram_we`  out  1  VRAM write enable (registered).
- `ram_addr`  out  AW  VRAM address (registered).
- `ram_wdata`  out  DW  VRAM write data (registered).
- `ram_rdata`  in  DW  VRAM read data, valid the cycle after an enabled read.
- `starve`  out  1  sticky: a CPU request waited >= `STARVE_LIMIT` cycles.

## Operation
- Each cycle the arbiter samples `vid_req` and `cpu_req` and issues at most one VRAM access in the next cycle.
- Priority: `vid_req` always wins. A CPU request sampled in the same cycle waits.
- CPU FSM states:
  - IDLE: if `cpu_req` is high and `vid_req` is low, latch `cpu_we`/`cpu_addr`/`cpu_wdata` and go to ISSUE. If both are high, stay in IDLE and increment the wait counter.
  - ISSUE: drive the CPU access on the VRAM port, then go to CAPTURE.
  - CAPTURE: register `ram_rdata` into `cpu_rdata` if it was a read (writes leave `cpu_rdata` unchanged), then go to ACK.
  - ACK: pulse `cpu_ack`, then go to IDLE.
- Video path is a 2-stage shift of (valid, read-tag) alongside the FSM. It never stalls and never blocks on CPU state.
- A `vid_req` arriving while the CPU FSM is in ISSUE/CAPTURE/ACK is still issued next cycle. The VRAM port is free because the CPU access occupies only the ISSUE cycle.
- Wait counter: 8-bit, saturating at 255, cleared on leaving IDLE. `starve` is set when the counter reaches `STARVE_LIMIT` and is cleared only by reset.
- `cpu_req` dropped while in IDLE: the request is abandoned and the counter cleared. `cpu_req` dropped after leaving IDLE: the access completes and `cpu_ack` still pulses.
- `cpu_req` sampled during ACK is ignored. A new request is accepted from the cycle after ACK.
- When no access is issued: `ram_en`=0 and `ram_we`=0; `ram_addr`/`ram_wdata` hold their previous values.

## Timing
- Reset (`rst`=0, asynchronous): FSM goes to IDLE and the video pipe is cleared. `vid_valid`, `cpu_ack`, `ram_en`, `ram_we`, `starve` are 0. `vid_data`, `cpu_rdata`, `ram_addr`, `ram_wdata` are 0. Wait counter is 0.
- Reset asserted mid-access: the in-flight access is dropped and no `vid_valid`/`cpu_ack` follows.
- Video: `vid_req` sampled in cycle N. Then `ram_en`=1, `ram_we`=0 in N+1; `ram_rdata` valid in N+2; `vid_valid`=1 in N+3. Fixed latency of 3, full throughput of one fetch per cycle.
- CPU, uncontended: request sampled in N; access on the port in N+1; `cpu_ack` in N+3 for both reads and writes. Back-to-back throughput is one access per 4 cycles; the next access is on the port at N+5 at the earliest.
- A write occurs in the ISSUE cycle (`ram_en`=1, `ram_we`=1).
- Contended CPU: the first video-free cycle in IDLE counts as cycle N for the rules above.

## Test plan
- Reset: hold `rst`=0 for 100 ns with random inputs -> all outputs are 0. Release, then `vid_req` at addr 0x0010 with RAM model data 0x5A -> `vid_valid` exactly 3 cycles later with `vid_data`=0x5A.
- CPU write then read: write 0xC3 to 0x1234, then read 0x1234 -> each `cpu_ack` arrives 3 cycles after the request is sampled; read returns `cpu_rdata`=0xC3; `ram_we` is high for exactly 1 cycle.
- Collision: `vid_req` and `cpu_req` (read 0x0100) in the same cycle, then `vid_req` held 0 -> the video access is on the port first, the CPU access the next cycle, `cpu_ack` 4 cycles after the collision; video latency is still 3.
- Continuous video: `vid_req`=1 for 70 cycles with `cpu_req` held -> 70 `vid_valid` pulses; `starve`=1 after 64 wait cycles; CPU ack 3 cycles after `vid_req` drops; `starve` stays 1.
- Abandon/late drop: drop `cpu_req` while blocked -> no access and no ack. Drop it in the ISSUE cycle -> ack still pulses 2 cycles later.
- Reset mid-read: assert `rst` in the CAPTURE cycle -> no `cpu_ack` and no `vid_valid` after reset is released.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win every slot with a fixed 3-cycle
// latency; CPU accesses use idle slots through a request/ack FSM.
module vram_arbiter #(
   parameter int unsigned AW           = 15,
   parameter int unsigned DW           = 8,
   parameter int unsigned STARVE_LIMIT = 64
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          vid_req_i,
   input  logic [AW-1:0] vid_addr_i,
   output logic          vid_valid_o,
   output logic [DW-1:0] vid_data_o,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          cpu_ack_o,
   output logic [DW-1:0] cpu_rdata_o,
   output logic          ram_en_o,
   output logic          ram_we_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [DW-1:0] ram_wdata_o,
   input  logic [DW-1:0] ram_rdata_i,
   output logic          starve_o
);

   localparam int unsigned       WAIT_W     = 8;
   localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_ACK     = 2'd3
   } state_e;

   state_e              state_q,     state_d;
   logic [WAIT_W-1:0]   wait_q,      wait_d;
   logic                starve_q,    starve_d;
   logic [1:0]          vid_pipe_q,  vid_pipe_d;
   logic                vid_valid_q, vid_valid_d;
   logic [DW-1:0]       vid_data_q,  vid_data_d;
   logic                cpu_ack_q,   cpu_ack_d;
   logic [DW-1:0]       cpu_rdata_q, cpu_rdata_d;
   logic                cpu_we_q,    cpu_we_d;
   logic                ram_en_q,    ram_en_d;
   logic                ram_we_q,    ram_we_d;
   logic [AW-1:0]       ram_addr_q,  ram_addr_d;
   logic [DW-1:0]       ram_wdata_q, ram_wdata_d;
   logic                cpu_go;

   // Next-state: CPU FSM, wait counter, video shift pipe and VRAM port mux
   always_comb begin
      state_d     = state_q;
      wait_d      = '0;
      starve_d    = starve_q;
      vid_pipe_d  = {vid_pipe_q[0], vid_req_i};
      vid_valid_d = vid_pipe_q[1];
      vid_data_d  = vid_pipe_q[1] ? ram_rdata_i : vid_data_q;
      cpu_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      cpu_we_d    = cpu_we_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      cpu_go      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cpu_req_i) begin
               if (vid_req_i) begin
                  wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
               end else begin
                  cpu_go  = 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (!cpu_we_q) begin
               cpu_rdata_d = ram_rdata_i;
            end
            cpu_ack_d = 1'b1;
            state_d   = S_ACK;
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Video owns the port whenever it asks; the CPU only launches from IDLE
      if (vid_req_i) begin
         ram_en_d   = 1'b1;
         ram_addr_d = vid_addr_i;
      end else if (cpu_go) begin
         ram_en_d    = 1'b1;
         ram_we_d    = cpu_we_i;
         ram_addr_d  = cpu_addr_i;
         ram_wdata_d = cpu_wdata_i;
         cpu_we_d    = cpu_we_i;
      end

      if (wait_d >= WAIT_LIMIT) begin
         starve_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         starve_q    <= 1'b0;
         vid_pipe_q  <= '0;
         vid_valid_q <= 1'b0;
         vid_data_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         cpu_we_q    <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
         vid_pipe_q  <= vid_pipe_d;
         vid_valid_q <= vid_valid_d;
         vid_data_q  <= vid_data_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_we_q    <= cpu_we_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign vid_valid_o = vid_valid_q;
   assign vid_data_o  = vid_data_q;
   assign cpu_ack_o   = cpu_ack_q;
   assign cpu_rdata_o = cpu_rdata_q;
   assign ram_en_o    = ram_en_q;
   assign ram_we_o    = ram_we_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wdata_o = ram_wdata_q;
   assign starve_o    = starve_q;

endmodule
